// File: rtl/clock_set_pkg.sv
// Shared types and helpers for the mm:ss time-entry controller.
package clock_set_pkg;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_SET_MIN,
    MODE_SET_SEC
  } set_mode_t;

  localparam logic [3:0] BLANK_MIN = 4'b1100;
  localparam logic [3:0] BLANK_SEC = 4'b0011;

  // One up/down step of a 0..max_val field with wrap in both directions.
  function automatic logic [7:0] field_step(input logic [7:0] v, input logic up,
                                            input logic [7:0] max_val);
    if (up) return (v >= max_val) ? 8'd0 : v + 8'd1;
    else    return (v == 8'd0) ? max_val : v - 8'd1;
  endfunction

  // Out-of-range running values are not editable; start such a field at 0.
  function automatic logic [7:0] field_clamp(input logic [7:0] v, input logic [7:0] max_val);
    return (v > max_val) ? 8'd0 : v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button to one-cycle press pulse: 2-flop synchronizer, stability counter,
// rising-edge detector on the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a, sync_b;
  logic          state, state_q;
  logic [CW-1:0] cnt;

  // NOTE: every register here is updated with <= so all flops sample the
  // pre-edge values; blocking assignments would collapse the synchronizer.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      state   <= 1'b0;
      state_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      state_q <= state;
      press   <= state & ~state_q;
      if (sync_b != state) begin
        if (cnt == CNT_LAST) begin
          state <= sync_b;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/clock_time_setter.sv
// Button-driven mm:ss time-entry controller: RUN -> SET_MIN -> SET_SEC -> RUN,
// field editing, one-cycle counter load, display mux and blink mask.
module clock_time_setter
  import clock_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_CYCLES    = 25_000_000,
  parameter int MAX_VAL         = 59
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic       run_en,
  output logic       load,
  output logic [7:0] load_min,
  output logic [7:0] load_sec,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic [3:0] blank_mask
);

  localparam logic [7:0] MAX_FIELD = 8'(MAX_VAL);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic mode_p, up_p, down_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .clr(clr), .raw(btn_mode), .press(mode_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .clr(clr), .raw(btn_up), .press(up_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .clr(clr), .raw(btn_down), .press(down_p)
  );

  set_mode_t     mode, mode_next;
  logic [7:0]    edit_min, edit_sec;
  logic [BW-1:0] blink_cnt;
  logic          blink_hidden;
  logic          edit_step;

  // A mode press takes priority over a simultaneous edit; up+down cancel.
  assign edit_step = (mode != MODE_RUN) && !mode_p && (up_p ^ down_p);

  // NOTE: mode_next and load get defaults before the case so no path leaves
  // them unassigned, which would otherwise infer latches.
  always_comb begin
    mode_next = mode;
    load      = 1'b0;
    if (mode_p) begin
      case (mode)
        MODE_RUN:     mode_next = MODE_SET_MIN;
        MODE_SET_MIN: mode_next = MODE_SET_SEC;
        MODE_SET_SEC: begin
          mode_next = MODE_RUN;
          load      = 1'b1;
        end
        default:      mode_next = MODE_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) mode <= MODE_RUN;
    else     mode <= mode_next;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      edit_min <= 8'd0;
      edit_sec <= 8'd0;
    end else if (mode == MODE_RUN && mode_p) begin
      edit_min <= field_clamp(cur_min, MAX_FIELD);
      edit_sec <= field_clamp(cur_sec, MAX_FIELD);
    end else if (edit_step) begin
      if (mode == MODE_SET_MIN) edit_min <= field_step(edit_min, up_p, MAX_FIELD);
      else                      edit_sec <= field_step(edit_sec, up_p, MAX_FIELD);
    end
  end

  // Restarting the blink on every transition or edit keeps the field solid
  // right after the user touches it.
  always_ff @(posedge clk) begin
    if (clr || mode_p || edit_step) begin
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else if (mode != MODE_RUN) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt    <= '0;
        blink_hidden <= ~blink_hidden;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    run_en     = (mode == MODE_RUN);
    load_min   = edit_min;
    load_sec   = edit_sec;
    disp_min   = run_en ? cur_min : edit_min;
    disp_sec   = run_en ? cur_sec : edit_sec;
    blank_mask = 4'b0000;
    if (blink_hidden) begin
      if (mode == MODE_SET_MIN)      blank_mask = BLANK_MIN;
      else if (mode == MODE_SET_SEC) blank_mask = BLANK_SEC;
    end
  end

endmodule

// File: tb/tb_clock_time_setter.sv
// Bench for clock_time_setter: directed scenarios with literal expectations,
// then random button/cur traffic checked every cycle against a behavioural model.
module tb_clock_time_setter;

  localparam int D    = 4;
  localparam int B    = 8;
  localparam int MAXV = 59;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [7:0] cur_min = 8'd0, cur_sec = 8'd0;
  logic       run_en, load;
  logic [7:0] load_min, load_sec, disp_min, disp_sec;
  logic [3:0] blank_mask;

  clock_time_setter #(.DEBOUNCE_CYCLES(D), .BLINK_CYCLES(B), .MAX_VAL(MAXV)) dut (
    .clk(clk), .clr(clr),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .cur_min(cur_min), .cur_sec(cur_sec),
    .run_en(run_en), .load(load), .load_min(load_min), .load_sec(load_sec),
    .disp_min(disp_min), .disp_sec(disp_sec), .blank_mask(blank_mask)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per button: synchronizer taps, debounced level, run length of disagreement,
  // and whether the level rose at the previous edge (that becomes the pulse).
  int s1[3], s2[3], lvl[3], run_len[3], rose[3], pulse[3];
  int m_mode;          // 0 RUN, 1 SET_MIN, 2 SET_SEC
  int m_em, m_es;
  int m_since;         // SET-state edges since the blink was last restarted

  function automatic int wrap_inc(input int v);
    return (v + 1) % (MAXV + 1);
  endfunction
  function automatic int wrap_dec(input int v);
    return (v + MAXV) % (MAXV + 1);
  endfunction

  task automatic model_step();
    int raw[3];
    int pm, pu, pd;
    raw[0] = int'(btn_mode);
    raw[1] = int'(btn_up);
    raw[2] = int'(btn_down);
    pm = pulse[0]; pu = pulse[1]; pd = pulse[2];
    if (clr) begin
      for (int b = 0; b < 3; b++) begin
        s1[b] = 0; s2[b] = 0; lvl[b] = 0; run_len[b] = 0; rose[b] = 0; pulse[b] = 0;
      end
      m_mode = 0; m_em = 0; m_es = 0; m_since = 0;
    end else begin
      if (pm != 0) begin
        if (m_mode == 0) begin
          m_em = (cur_min > MAXV) ? 0 : int'(cur_min);
          m_es = (cur_sec > MAXV) ? 0 : int'(cur_sec);
        end
        m_mode  = (m_mode + 1) % 3;
        m_since = 0;
      end else if (m_mode != 0 && pu != pd) begin
        if (m_mode == 1) m_em = (pu != 0) ? wrap_inc(m_em) : wrap_dec(m_em);
        else             m_es = (pu != 0) ? wrap_inc(m_es) : wrap_dec(m_es);
        m_since = 0;
      end else if (m_mode != 0) begin
        m_since++;
      end
      for (int b = 0; b < 3; b++) begin
        pulse[b] = rose[b];
        rose[b]  = 0;
        if (s2[b] != lvl[b]) begin
          run_len[b]++;
          if (run_len[b] == D) begin
            rose[b]    = (s2[b] == 1) ? 1 : 0;
            lvl[b]     = s2[b];
            run_len[b] = 0;
          end
        end else begin
          run_len[b] = 0;
        end
        s2[b] = s1[b];
        s1[b] = raw[b];
      end
    end
  endtask

  task automatic model_compare();
    int exp_blank;
    int hidden;
    hidden    = (m_since / B) % 2;
    exp_blank = (hidden == 1 && m_mode == 1) ? 4'b1100 :
                (hidden == 1 && m_mode == 2) ? 4'b0011 : 0;
    check("m_run_en", run_en, (m_mode == 0) ? 1 : 0);
    check("m_load", load, (m_mode == 2 && pulse[0] == 1) ? 1 : 0);
    check("m_disp_min", disp_min, (m_mode == 0) ? int'(cur_min) : m_em);
    check("m_disp_sec", disp_sec, (m_mode == 0) ? int'(cur_sec) : m_es);
    check("m_blank", blank_mask, exp_blank);
    if (m_mode == 2 && pulse[0] == 1) begin
      check("m_load_min", load_min, m_em);
      check("m_load_sec", load_sec, m_es);
    end
  endtask

  bit model_done = 1'b0;
  initial begin
    while (!model_done) begin
      @(posedge clk);
      model_step();
      #1;
      model_compare();
    end
  end

  // Observation of load pulses for the directed scenarios.
  int load_seen = 0;
  int last_lm = -1, last_ls = -1;
  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_seen++;
      last_lm = int'(load_min);
      last_ls = int'(load_sec);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the selected buttons long enough for one press, then release fully.
  task automatic press(input bit m, input bit u, input bit d);
    btn_mode = m; btn_up = u; btn_down = d;
    cycles(D + 3);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cycles(D + 4);
  endtask

  task automatic press_n(input bit u, input bit d, input int n);
    for (int i = 0; i < n; i++) press(1'b0, u, d);
  endtask

  initial begin
    cur_min = 8'd12; cur_sec = 8'd34;
    clr = 1'b1;
    cycles(2);
    clr = 1'b0;
    cycles(1);
    check("rst_run_en", run_en, 1);
    check("rst_load", load, 0);
    check("rst_blank", blank_mask, 0);
    check("rst_disp_min", disp_min, 12);
    check("rst_disp_sec", disp_sec, 34);

    // A 3-cycle glitch must not be accepted.
    btn_mode = 1'b1; cycles(3); btn_mode = 1'b0; cycles(10);
    check("glitch_no_press", run_en, 1);

    // Held mode press: pulse after edge 7, state changes at edge 8.
    btn_mode = 1'b1;
    cycles(7);
    check("lat_edge7_run", run_en, 1);
    cycles(1);
    check("lat_edge8_set", run_en, 0);
    check("cap_min", disp_min, 12);
    check("cap_sec", disp_sec, 34);
    check("blink_e8", blank_mask, 0);
    cycles(7);
    check("blink_e15", blank_mask, 0);
    cycles(1);
    check("blink_e16", blank_mask, 4'b1100);
    cycles(7);
    check("blink_e23", blank_mask, 4'b1100);
    cycles(1);
    check("blink_e24", blank_mask, 0);
    btn_mode = 1'b0;
    cycles(D + 4);
    check("release_no_press", run_en, 0);

    // Minute field wrapping.
    press_n(1'b0, 1'b1, 13);
    check("min_down_wrap", disp_min, 59);
    press_n(1'b1, 1'b0, 1);
    check("min_up_wrap", disp_min, 0);
    press_n(1'b0, 1'b1, 1);
    check("min_down_again", disp_min, 59);
    press_n(1'b1, 1'b0, 6);
    check("min_to_5", disp_min, 5);
    press(1'b0, 1'b1, 1'b1);
    check("up_down_same", disp_min, 5);

    // Second field, then commit.
    press(1'b1, 1'b0, 1'b0);
    check("sec_mode", disp_sec, 34);
    press_n(1'b0, 1'b1, 34);
    check("sec_to_0", disp_sec, 0);
    press_n(1'b0, 1'b1, 1);
    check("sec_down_wrap", disp_sec, 59);
    load_seen = 0;
    press(1'b1, 1'b0, 1'b0);
    check("load_count", load_seen, 1);
    check("load_min_val", last_lm, 5);
    check("load_sec_val", last_ls, 59);
    check("back_to_run", run_en, 1);

    // Mode wins over a simultaneous up.
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    check("mode_up_min", disp_min, 12);
    check("mode_up_state", run_en, 0);

    // Reset while in SET_SEC abandons the edit without a load.
    load_seen = 0;
    clr = 1'b1; cycles(1); clr = 1'b0;
    cycles(20);
    check("clr_no_load", load_seen, 0);
    check("clr_run_en", run_en, 1);

    // Out-of-range capture clamps to 0.
    cur_min = 8'd75; cur_sec = 8'd10;
    press(1'b1, 1'b0, 1'b0);
    check("clamp_min", disp_min, 0);
    check("clamp_sec", disp_sec, 10);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("clamp_return", run_en, 1);

    // Random traffic, checked each cycle by the model.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 15) begin
        cur_min = 8'($urandom_range(0, 99));
        cur_sec = 8'($urandom_range(0, 99));
        cycles(1);
      end else if (sel < 18) begin
        clr = 1'b1; cycles(int'($urandom_range(1, 2))); clr = 1'b0;
      end else begin
        btn_mode = ($urandom_range(0, 3) == 0);
        btn_up   = ($urandom_range(0, 1) == 0);
        btn_down = ($urandom_range(0, 2) == 0);
        cycles(int'($urandom_range(1, 12)));
        if ($urandom_range(0, 1) == 0) begin
          btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
          cycles(int'($urandom_range(1, 20)));
        end
      end
    end
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cycles(20);

    model_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
